// File: rtl/uart_rx_ctrl.sv
// UART receive control: owns the receiver configuration, applies changes only on an
// idle line, and buffers good frames in a first-word fall-through FIFO with status.
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic                     cfg_wr,
  input  logic [4:0]               cfg_prescale,
  input  logic                     cfg_par_en,
  input  logic                     cfg_par_typ,
  output logic                     cfg_busy,
  output logic                     cfg_reject,
  output logic [4:0]               Prescale,
  output logic                     PAR_EN,
  output logic                     PAR_TYP,
  input  logic [7:0]               rx_p_data,
  input  logic                     rx_data_valid,
  input  logic                     rx_par_error,
  input  logic                     rx_stop_error,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun,
  output logic [CNT_W-1:0]         err_count,
  input  logic                     clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, PENDING} cfg_state_t;

  cfg_state_t state, state_nxt;
  logic [4:0] held_ps, held_ps_nxt;
  logic       held_en, held_en_nxt;
  logic       held_typ, held_typ_nxt;
  logic [4:0] act_ps_nxt;
  logic       act_en_nxt, act_typ_nxt;
  logic       reject_nxt;

  logic [8:0] idle_cnt;
  logic [8:0] idle_thresh;
  logic       line_idle;
  logic       ps_legal;

  // Line counts as idle after a full 11-bit frame time of marking at the active rate
  assign idle_thresh = {1'b0, Prescale, 3'b000} + {3'b000, Prescale, 1'b0} + {4'b0000, Prescale};
  assign line_idle   = (idle_cnt >= idle_thresh);
  assign ps_legal    = (cfg_prescale == 5'd8) || (cfg_prescale == 5'd16);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt <= '0;
    end else if (!RX_IN) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 9'd511) begin
      idle_cnt <= idle_cnt + 9'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      held_ps    <= 5'd8;
      held_en    <= 1'b1;
      held_typ   <= 1'b0;
      Prescale   <= 5'd8;
      PAR_EN     <= 1'b1;
      PAR_TYP    <= 1'b0;
      cfg_reject <= 1'b0;
    end else begin
      state      <= state_nxt;
      held_ps    <= held_ps_nxt;
      held_en    <= held_en_nxt;
      held_typ   <= held_typ_nxt;
      Prescale   <= act_ps_nxt;
      PAR_EN     <= act_en_nxt;
      PAR_TYP    <= act_typ_nxt;
      cfg_reject <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    held_ps_nxt  = held_ps;
    held_en_nxt  = held_en;
    held_typ_nxt = held_typ;
    act_ps_nxt   = Prescale;
    act_en_nxt   = PAR_EN;
    act_typ_nxt  = PAR_TYP;
    reject_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_wr) begin
          if (ps_legal) begin
            held_ps_nxt  = cfg_prescale;
            held_en_nxt  = cfg_par_en;
            held_typ_nxt = cfg_par_typ;
            state_nxt    = PENDING;
          end else begin
            reject_nxt = 1'b1;
          end
        end
      end
      PENDING: begin
        if (cfg_wr) begin
          reject_nxt = 1'b1;
        end
        if (line_idle) begin
          act_ps_nxt  = held_ps;
          act_en_nxt  = held_en;
          act_typ_nxt = held_typ;
          state_nxt   = IDLE;
        end
      end
    endcase
  end

  assign cfg_busy = (state == PENDING);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    last_q;
  logic          empty, full, good, push, pop, drop;

  assign empty   = (fifo_level == '0);
  assign full    = (fifo_level == LW'(DEPTH));
  assign good    = rx_data_valid && !rx_par_error && !rx_stop_error;
  assign pop     = !empty && m_ready;
  assign push    = good && (!full || pop);
  assign drop    = good && full && !pop;
  assign m_valid = !empty;
  assign m_data  = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= rx_p_data;
    end
  end

  // last_q keeps the most recently popped byte visible once the FIFO runs dry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  logic err_in, err_prev, err_event;

  assign err_in    = rx_par_error || rx_stop_error;
  assign err_event = err_in && !err_prev;

  // A fresh event or drop in the clearing cycle takes priority over the clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_prev  <= 1'b0;
      err_count <= '0;
      overrun   <= 1'b0;
    end else begin
      err_prev <= err_in;
      if (err_event) begin
        if (clr_status) begin
          err_count <= CNT_W'(1);
        end else if (err_count != {CNT_W{1'b1}}) begin
          err_count <= err_count + CNT_W'(1);
        end
      end else if (clr_status) begin
        err_count <= '0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus, popped bytes checked against a queue of
// expected bytes by a monitor that runs alongside the stimulus.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   RX_IN = 1'b1;
  logic                   cfg_wr = 1'b0;
  logic [4:0]             cfg_prescale = 5'd0;
  logic                   cfg_par_en = 1'b0;
  logic                   cfg_par_typ = 1'b0;
  logic                   cfg_busy;
  logic                   cfg_reject;
  logic [4:0]             Prescale;
  logic                   PAR_EN;
  logic                   PAR_TYP;
  logic [7:0]             rx_p_data = 8'h00;
  logic                   rx_data_valid = 1'b0;
  logic                   rx_par_error = 1'b0;
  logic                   rx_stop_error = 1'b0;
  logic [7:0]             m_data;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overrun;
  logic [CNT_W-1:0]       err_count;
  logic                   clr_status = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
    .cfg_par_typ(cfg_par_typ), .cfg_busy(cfg_busy), .cfg_reject(cfg_reject),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .rx_p_data(rx_p_data), .rx_data_valid(rx_data_valid),
    .rx_par_error(rx_par_error), .rx_stop_error(rx_stop_error),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overrun(overrun), .err_count(err_count),
    .clr_status(clr_status)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop);
    rx_p_data     = data;
    rx_data_valid = 1'b1;
    rx_par_error  = par;
    rx_stop_error = stop;
    tick(1);
    rx_data_valid = 1'b0;
    rx_par_error  = 1'b0;
    rx_stop_error = 1'b0;
  endtask

  task automatic write_cfg(input logic [4:0] ps, input logic en, input logic typ);
    cfg_prescale = ps;
    cfg_par_en   = en;
    cfg_par_typ  = typ;
    cfg_wr       = 1'b1;
    tick(1);
    cfg_wr       = 1'b0;
  endtask

  task automatic run_monitor();
    forever begin
      @(negedge CLK);
      if (RST && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no byte", m_data);
        end else begin
          checkOutput("fifo_pop", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic drain();
    int budget = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 20) begin
      tick(1);
      budget++;
    end
    m_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic check_reset_values();
    checkOutput("rst_prescale", 32'(Prescale), 32'd8);
    checkOutput("rst_par_en", 32'(PAR_EN), 32'd1);
    checkOutput("rst_par_typ", 32'(PAR_TYP), 32'd0);
    checkOutput("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    checkOutput("rst_cfg_reject", 32'(cfg_reject), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fork
      run_monitor();
    join_none

    #1 RST = 1'b0;
    #2 check_reset_values();
    tick(3);
    RST = 1'b1;

    // Already-idle line: new configuration lands one edge after the write
    tick(200);
    write_cfg(5'd16, 1'b0, 1'b1);
    checkOutput("cfg_busy_after_write", 32'(cfg_busy), 32'd1);
    checkOutput("prescale_before_apply", 32'(Prescale), 32'd8);
    tick(1);
    checkOutput("cfg_busy_cleared", 32'(cfg_busy), 32'd0);
    checkOutput("prescale_applied", 32'(Prescale), 32'd16);
    checkOutput("par_en_applied", 32'(PAR_EN), 32'd0);
    checkOutput("par_typ_applied", 32'(PAR_TYP), 32'd1);

    write_cfg(5'd8, 1'b1, 1'b0);
    tick(1);
    checkOutput("prescale_back_to_8", 32'(Prescale), 32'd8);

    // Busy line: write held until 88 marking cycles, second write rejected
    RX_IN = 1'b0;
    tick(2);
    write_cfg(5'd16, 1'b0, 1'b1);
    checkOutput("cfg_busy_line_low", 32'(cfg_busy), 32'd1);
    tick(3);
    checkOutput("cfg_busy_still", 32'(cfg_busy), 32'd1);
    write_cfg(5'd8, 1'b1, 1'b0);
    checkOutput("cfg_reject_pending", 32'(cfg_reject), 32'd1);
    tick(1);
    checkOutput("cfg_reject_one_cycle", 32'(cfg_reject), 32'd0);
    RX_IN = 1'b1;
    tick(88);
    checkOutput("prescale_at_T87", 32'(Prescale), 32'd8);
    checkOutput("cfg_busy_at_T87", 32'(cfg_busy), 32'd1);
    tick(1);
    checkOutput("prescale_at_T88", 32'(Prescale), 32'd16);
    checkOutput("par_en_held", 32'(PAR_EN), 32'd0);
    checkOutput("par_typ_held", 32'(PAR_TYP), 32'd1);
    checkOutput("cfg_busy_at_T88", 32'(cfg_busy), 32'd0);

    write_cfg(5'd12, 1'b1, 1'b0);
    checkOutput("cfg_reject_illegal", 32'(cfg_reject), 32'd1);
    checkOutput("cfg_busy_illegal", 32'(cfg_busy), 32'd0);
    checkOutput("prescale_illegal", 32'(Prescale), 32'd16);
    tick(1);
    checkOutput("cfg_reject_clear", 32'(cfg_reject), 32'd0);

    // Five frames into a four-deep FIFO: fifth dropped
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA1 + 8'(i));
    for (int i = 0; i < 5; i++) applyStimulus(8'hA1 + 8'(i), 1'b0, 1'b0);
    checkOutput("level_full", 32'(fifo_level), 32'd4);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    checkOutput("m_valid_full", 32'(m_valid), 32'd1);
    checkOutput("m_data_head", 32'(m_data), 32'hA1);
    drain();
    checkOutput("level_drained", 32'(fifo_level), 32'd0);
    checkOutput("m_valid_empty", 32'(m_valid), 32'd0);
    checkOutput("m_data_hold", 32'(m_data), 32'hA4);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    checkOutput("ready_while_empty", 32'(fifo_level), 32'd0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hB1 + 8'(i));
      applyStimulus(8'hB1 + 8'(i), 1'b0, 1'b0);
    end
    checkOutput("level_full_b", 32'(fifo_level), 32'd4);
    exp_q.push_back(8'h5A);
    m_ready = 1'b1;
    applyStimulus(8'h5A, 1'b0, 1'b0);
    m_ready = 1'b0;
    checkOutput("level_push_pop", 32'(fifo_level), 32'd4);
    checkOutput("overrun_push_pop", 32'(overrun), 32'd0);
    checkOutput("m_data_after_pop", 32'(m_data), 32'hB2);
    drain();

    // Error events: a held level counts once
    rx_par_error = 1'b1;
    tick(3);
    rx_par_error = 1'b0;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      rx_stop_error = 1'b1;
      tick(1);
      rx_stop_error = 1'b0;
      tick(2);
    end
    checkOutput("err_count_3", 32'(err_count), 32'd3);
    applyStimulus(8'hEE, 1'b1, 1'b0);
    tick(1);
    checkOutput("bad_frame_not_pushed", 32'(fifo_level), 32'd0);
    checkOutput("err_count_4", 32'(err_count), 32'd4);
    clr_status    = 1'b1;
    rx_stop_error = 1'b1;
    tick(1);
    clr_status    = 1'b0;
    rx_stop_error = 1'b0;
    checkOutput("clr_with_event", 32'(err_count), 32'd1);
    tick(1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    checkOutput("clr_alone", 32'(err_count), 32'd0);
    for (int i = 0; i < 300; i++) begin
      rx_par_error = 1'b1;
      tick(1);
      rx_par_error = 1'b0;
      tick(1);
    end
    checkOutput("err_count_saturated", 32'(err_count), 32'd255);

    // Reset mid-stream drops buffered bytes and the pending configuration
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hC1 + 8'(i));
      applyStimulus(8'hC1 + 8'(i), 1'b0, 1'b0);
    end
    RX_IN = 1'b0;
    write_cfg(5'd8, 1'b0, 1'b0);
    checkOutput("pending_before_reset", 32'(cfg_busy), 32'd1);
    checkOutput("level_before_reset", 32'(fifo_level), 32'd3);
    RST = 1'b0;
    #2;
    exp_q.delete();
    check_reset_values();
    tick(2);
    RST   = 1'b1;
    RX_IN = 1'b1;
    tick(1);
    checkOutput("post_reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("post_reset_busy", 32'(cfg_busy), 32'd0);
    checkOutput("post_reset_prescale", 32'(Prescale), 32'd8);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block for the UART receiver. Owns the receiver configuration (Prescale, PAR_EN, PAR_TYP) and applies configuration changes only when the serial line is idle, so a frame in flight is never corrupted. Buffers received bytes in a small FIFO with a valid/ready consumer port, and keeps overrun and error status. Sits between the UART receive core, which it drives and monitors, and the system-side byte consumer.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 8, error counter width
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- RX_IN  in  1  serial line, monitored only for idle detection
- cfg_wr  in  1  configuration write strobe
- cfg_prescale  in  5  requested oversampling; only 8 or 16 are legal
- cfg_par_en  in  1  requested parity enable
- cfg_par_typ  in  1  requested parity type; 0 = even, 1 = odd
- cfg_busy  out  1  a configuration is pending and not yet applied
- cfg_reject  out  1  one-cycle pulse: write ignored
- Prescale / PAR_EN / PAR_TYP  out  5/1/1  active configuration driven to the receive core
- rx_p_data  in  8  received byte from the core
- rx_data_valid  in  1  one-cycle frame-good pulse from the core
- rx_par_error / rx_stop_error  in  1/1  error flags from the core
- m_data  out  8  FIFO head byte
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts the head byte
- fifo_level  out  $clog2(DEPTH)+1  number of stored bytes
- overrun  out  1  sticky: a byte was dropped
- err_count  out  CNT_W  saturating count of error events
- clr_status  in  1  clears overrun and err_count

## Operation
- Reset values: Prescale=8, PAR_EN=1, PAR_TYP=0, cfg_busy=0, cfg_reject=0, FIFO empty (m_valid=0, fifo_level=0, m_data=0), overrun=0, err_count=0, idle counter=0. A reset asserted mid-operation drops the pending configuration and all buffered bytes.
- Idle counter (9 bits):
  - Increments on every cycle with RX_IN=1 and saturates at 511.
  - Clears to 0 on any cycle with RX_IN=0.
  - The line is idle when the count is at least 11*Prescale, using the active Prescale (88 or 176 cycles).
- Configuration state machine, states IDLE and PENDING:
  - IDLE, cfg_wr=1, cfg_prescale in {8,16}: capture all three cfg values and move to PENDING.
  - IDLE, cfg_wr=1, any other cfg_prescale: no capture and stay in IDLE. cfg_reject pulses for one cycle.
  - PENDING, cfg_wr=1: write ignored and cfg_reject pulses. The held values are unchanged.
  - PENDING, line idle: load Prescale, PAR_EN and PAR_TYP from the held values and return to IDLE on the same edge.
  - cfg_busy is 1 exactly while in PENDING.
- Receive path:
  - A cycle with rx_data_valid=1 and both error inputs 0 is a good frame.
  - A good frame pushes rx_p_data into the FIFO if the FIFO is not full.
  - If the FIFO is full and a pop happens in the same cycle, the push still succeeds and the level is unchanged.
  - If the FIFO is full and there is no pop, the byte is dropped and overrun is set.
  - A cycle with rx_data_valid=1 and any error input high is not pushed.
- Error events:
  - An event is a rising edge of (rx_par_error | rx_stop_error), detected against the registered previous value.
  - Each event increments err_count, which saturates at 2^CNT_W-1.
  - A level held high counts once.
- clr_status: on the edge it is sampled, overrun and err_count clear. A new event or overrun in that same cycle wins, giving err_count=1 or overrun=1.
- FIFO:
  - First-word fall-through: m_data always shows the head byte.
  - A pop occurs on m_valid & m_ready.
  - Read and write pointers wrap modulo DEPTH.
  - When empty, m_data holds its last value.
  - m_ready while empty has no effect.

## Timing
- Push latency: rx_data_valid in cycle N gives m_valid=1 and the byte on m_data in cycle N+1.
- Pop: the head advances and fifo_level decrements at the edge where m_valid & m_ready is sampled.
- Configuration:
  - A write accepted at edge E sets cfg_busy=1 from edge E.
  - The idle check runs from edge E+1 onward.
  - On an already-idle line, the new configuration appears and cfg_busy=0 at edge E+1.
- cfg_reject, err_count and overrun update one edge after the causing input is sampled.
- All outputs are registered except m_valid and m_data, which are decoded directly from the FIFO state registers.

## Test plan
- Line idle for 200 cycles, then cfg_wr with prescale=16, par_en=0, par_typ=1 -> cfg_busy high for exactly 1 cycle, then Prescale=16, PAR_EN=0, PAR_TYP=1.
- RX_IN held low, cfg_wr with prescale=16, then RX_IN=1 from cycle T -> config applied at edge T+88. A second cfg_wr during PENDING gives a cfg_reject pulse and the held values are unchanged. cfg_wr with prescale=12 gives a cfg_reject pulse and no state change.
- Five good frames 0xA1..0xA5 with m_ready=0 and DEPTH=4 -> fifo_level=4, overrun=1. Draining then yields A1, A2, A3, A4.
- FIFO full, good frame 0x5A coincident with a pop -> no overrun, level stays 4, 0x5A is last out.
- rx_par_error held high for 3 cycles, then rx_stop_error pulsed twice -> err_count=3. clr_status coincident with a new error edge gives err_count=1. 300 events give err_count=255.
- RST low mid-stream with 3 bytes stored and a config pending -> all outputs at reset values, Prescale=8, cfg_busy=0.
